flash_read_arbiter: RTL and testbench
=====================================

# flash_read_arbiter

Shares the single Avalon-MM flash read port between two requesters: the audio sample fetcher (port A) and the song-table/metadata reader (port B). Accepts one word-read request at a time, drives the flash read handshake (read, waitrequest, readdatavalid), and returns the 32-bit word to the requester that issued it. Fair round-robin grant when both requesters are pending; a watchdog ends any read whose data never returns. Sits between the player control FSMs and the flash controller IP.

## Interface
- ADDR_W, 23, flash word address width
- DATA_W, 32, flash read data width
- TIMEOUT, 255, max cycles waiting for readdatavalid after the read is accepted (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_a_valid  in  1  requester A has a read pending; holds valid/addr until ready
- req_a_addr  in  ADDR_W  word address for A
- req_a_ready  out  1  combinational accept strobe for A
- rsp_a_valid  out  1  one-cycle pulse: rsp_a_data valid
- rsp_a_data  out  DATA_W  returned word for A
- req_b_valid, req_b_addr, req_b_ready, rsp_b_valid, rsp_b_data: same as A, for requester B
- flash_mem_read  out  1  Avalon read strobe
- flash_mem_address  out  ADDR_W  Avalon address
- flash_mem_byteenable  out  DATA_W/8  constant all-ones while read is high, else 0
- flash_mem_waitrequest  in  1  slave stall
- flash_mem_readdata  in  DATA_W  slave read data
- flash_mem_readdatavalid  in  1  slave data strobe
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE, ISSUE, WAIT_DATA, RESPOND.
- IDLE: A wins if only A is valid; B wins if only B is valid. If both are valid, the requester not served last wins. Priority pointer resets to A. The winner's ready is high this cycle. At the edge, latch the address and owner id, then go to ISSUE.
- ISSUE: read=1, address=latched address. Hold while waitrequest=1. Waitrequest is not watchdog-timed. On an edge with waitrequest=0, go to WAIT_DATA; read falls in the next cycle.
- WAIT_DATA: the counter increments each cycle.
  - On readdatavalid: latch readdata, go to RESPOND.
  - If the counter reaches TIMEOUT first: latch data=0, set the error flag, go to RESPOND.
- RESPOND: the owner's rsp_valid=1 for exactly one cycle with the latched data. timeout_err=1 in the same cycle if the error flag is set. Update the priority pointer to the other requester, clear the counter and flag, go to IDLE.
- readdatavalid is ignored in IDLE, ISSUE and RESPOND; it must not corrupt rsp data.
- rsp_x_data holds its last value between pulses.
- The non-owner's rsp_valid never asserts.

## Timing
- Reset (async, immediate):
  - State IDLE; pointer → A; counter and flag cleared.
  - Outputs: flash_mem_read=0, address=0, byteenable=0, both ready=0, both rsp_valid=0, both rsp_data=0, busy=0, timeout_err=0.
- Reset mid-read drops read combinationally-fast via the async clear. Late readdatavalid after reset is ignored.
- Minimum latency: accept edge T0; read high T1; waitrequest=0 at T1 → WAIT_DATA T2; readdatavalid at T2 → rsp_valid at T3.
- Each waitrequest cycle adds one cycle; each readdatavalid delay cycle adds one cycle.
- Throughput: one read per ≥4 cycles. The next accept is earliest the cycle after RESPOND.
- Only one read is outstanding at a time; no pipelined reads.
- Watchdog: with no readdatavalid, rsp_valid and timeout_err rise exactly TIMEOUT+1 cycles after entering WAIT_DATA.
- A simultaneous readdatavalid and counter==TIMEOUT counts as valid data, not an error.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Structure
- Package flash_arb_pkg: state enum (IDLE, ISSUE, WAIT_DATA, RESPOND), owner enum (OWN_A, OWN_B), default ADDR_W/DATA_W localparams.
- Sub-module flash_rr_pick: combinational 2-way round-robin chooser. Inputs valid_a, valid_b, last_owner; outputs grant_a, grant_b. The pointer register stays in the top level.

## Test plan
- Single A read, addr 0x000010, waitrequest=0, readdatavalid one cycle after read ends, data 0xDEADBEEF → rsp_a_valid 1 cycle at T3 with 0xDEADBEEF; rsp_b_valid stays 0.
- A and B valid together out of reset (addrs 0x100, 0x200) → A served first, then B; flash_mem_address shows 0x100, then 0x200; each gets its own data.
- Waitrequest held 5 cycles in ISSUE → read and address stable all 6 cycles; read falls the cycle after waitrequest drops; no timeout.
- TIMEOUT=8, readdatavalid never asserted → rsp_b_valid and timeout_err pulse together 9 cycles after WAIT_DATA entry, rsp_b_data=0; next request is accepted normally.
- Spurious readdatavalid in IDLE with data 0x12345678 → no rsp pulse, rsp data unchanged.
- rst asserted during ISSUE → read low immediately, state IDLE; a subsequent readdatavalid is ignored; the pointer restarts at A.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared types for the flash read arbiter: FSM states, request owner ids,
// and the default Avalon flash port widths.
package flash_arb_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int FLASH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

endpackage

// File: rtl/flash_rr_pick.sv
// Two-way round-robin chooser: a lone requester always wins, and on a tie
// the requester that was not served last gets the grant.
module flash_rr_pick
    import flash_arb_pkg::*;
(
    input  logic   valid_a,
    input  logic   valid_b,
    input  owner_t last_owner,
    output logic   grant_a,
    output logic   grant_b
);

    assign grant_a = valid_a && (!valid_b || (last_owner == OWN_B));
    assign grant_b = valid_b && (!valid_a || (last_owner == OWN_A));

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one Avalon-MM flash read port between the sample fetcher (A) and the
// song-table reader (B); one read in flight, with a readdatavalid watchdog.
//
// state     | meaning
// IDLE      | waiting for a request, winner's ready asserted
// ISSUE     | read strobe high until waitrequest drops
// WAIT_DATA | waiting for readdatavalid, watchdog counting
// RESPOND   | one-cycle response pulse to the owner
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W  = FLASH_ADDR_W,
    parameter int DATA_W  = FLASH_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_a_valid,
    input  logic [ADDR_W-1:0]   req_a_addr,
    output logic                req_a_ready,
    output logic                rsp_a_valid,
    output logic [DATA_W-1:0]   rsp_a_data,
    input  logic                req_b_valid,
    input  logic [ADDR_W-1:0]   req_b_addr,
    output logic                req_b_ready,
    output logic                rsp_b_valid,
    output logic [DATA_W-1:0]   rsp_b_data,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [DATA_W/8-1:0] flash_mem_byteenable,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic                busy,
    output logic                timeout_err
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    owner_t              owner_q, prio_q, last_owner;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic [DATA_W-1:0]   rsp_a_data_q, rsp_b_data_q;
    logic                grant_a, grant_b;

    // prio_q names who wins the next tie; the chooser wants who went last.
    assign last_owner = (prio_q == OWN_A) ? OWN_B : OWN_A;

    flash_rr_pick u_pick (
        .valid_a    (req_a_valid),
        .valid_b    (req_b_valid),
        .last_owner (last_owner),
        .grant_a    (grant_a),
        .grant_b    (grant_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (grant_a || grant_b) state_d = ISSUE;
            ISSUE:     if (!flash_mem_waitrequest) state_d = WAIT_DATA;
            WAIT_DATA: if (flash_mem_readdatavalid || (cnt_q == CNT_MAX)) state_d = RESPOND;
            RESPOND:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_a_ready          = 1'b0;
        req_b_ready          = 1'b0;
        rsp_a_valid          = 1'b0;
        rsp_b_valid          = 1'b0;
        flash_mem_read       = 1'b0;
        flash_mem_address    = '0;
        flash_mem_byteenable = '0;
        busy                 = 1'b0;
        timeout_err          = 1'b0;
        case (state_q)
            IDLE: begin
                req_a_ready = grant_a && !rst;
                req_b_ready = grant_b && !rst;
            end
            ISSUE: begin
                flash_mem_read       = 1'b1;
                flash_mem_address    = addr_q;
                flash_mem_byteenable = '1;
                busy                 = 1'b1;
            end
            WAIT_DATA: busy = 1'b1;
            RESPOND: begin
                busy        = 1'b1;
                rsp_a_valid = (owner_q == OWN_A);
                rsp_b_valid = (owner_q == OWN_B);
                timeout_err = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            owner_q      <= OWN_A;
            prio_q       <= OWN_A;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rsp_a_data_q <= '0;
            rsp_b_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        addr_q  <= grant_a ? req_a_addr : req_b_addr;
                        owner_q <= grant_a ? OWN_A : OWN_B;
                    end
                end
                WAIT_DATA: begin
                    // Data arriving on the terminal count still counts as good data.
                    if (flash_mem_readdatavalid) begin
                        if (owner_q == OWN_A) rsp_a_data_q <= flash_mem_readdata;
                        else                  rsp_b_data_q <= flash_mem_readdata;
                    end else if (cnt_q == CNT_MAX) begin
                        if (owner_q == OWN_A) rsp_a_data_q <= '0;
                        else                  rsp_b_data_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    prio_q <= (owner_q == OWN_A) ? OWN_B : OWN_A;
                    cnt_q  <= '0;
                    err_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_a_data = rsp_a_data_q;
    assign rsp_b_data = rsp_b_data_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with TIMEOUT=8: latency, round-robin,
// waitrequest stretch, watchdog, spurious data strobes and mid-read reset.
module tb_flash_read_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk, rst;
    logic          req_a_valid, req_a_ready, rsp_a_valid;
    logic [AW-1:0] req_a_addr;
    logic [DW-1:0] rsp_a_data;
    logic          req_b_valid, req_b_ready, rsp_b_valid;
    logic [AW-1:0] req_b_addr;
    logic [DW-1:0] rsp_b_data;
    logic          flash_mem_read, flash_mem_waitrequest, flash_mem_readdatavalid;
    logic [AW-1:0] flash_mem_address;
    logic [DW/8-1:0] flash_mem_byteenable;
    logic [DW-1:0] flash_mem_readdata;
    logic          busy, timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_a_valid             (req_a_valid),
        .req_a_addr              (req_a_addr),
        .req_a_ready             (req_a_ready),
        .rsp_a_valid             (rsp_a_valid),
        .rsp_a_data              (rsp_a_data),
        .req_b_valid             (req_b_valid),
        .req_b_addr              (req_b_addr),
        .req_b_ready             (req_b_ready),
        .rsp_b_valid             (rsp_b_valid),
        .rsp_b_data              (rsp_b_data),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_byteenable    (flash_mem_byteenable),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .busy                    (busy),
        .timeout_err             (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read from IDLE; valids/addrs already driven by the caller.
    task automatic txn(input logic exp_b, input logic [AW-1:0] exp_addr,
                       input int ws, input int dly, input logic [DW-1:0] d);
        #1;
        check("ready_a", req_a_ready, !exp_b);
        check("ready_b", req_b_ready, exp_b);
        tick();
        if (exp_b) req_b_valid = 1'b0;
        else       req_a_valid = 1'b0;
        for (int i = 0; i <= ws; i++) begin
            flash_mem_waitrequest   = (i < ws);
            flash_mem_readdatavalid = (i < ws);
            flash_mem_readdata      = 32'hBADBAD00 + i;
            #1;
            check("issue_read", flash_mem_read, 1'b1);
            check("issue_addr", flash_mem_address, exp_addr);
            check("issue_be", flash_mem_byteenable, 4'hF);
            tick();
        end
        flash_mem_readdatavalid = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        #1;
        check("wait_read_low", flash_mem_read, 1'b0);
        for (int j = 0; j < dly; j++) begin
            check("wait_no_rsp", rsp_a_valid | rsp_b_valid, 1'b0);
            tick();
        end
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = d;
        tick();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0BAD0BAD;
        #1;
        check("rsp_a_valid", rsp_a_valid, !exp_b);
        check("rsp_b_valid", rsp_b_valid, exp_b);
        check("rsp_data", exp_b ? rsp_b_data : rsp_a_data, d);
        check("rsp_no_tmo", timeout_err, 1'b0);
        tick();
        check("rsp_pulse_end", rsp_a_valid | rsp_b_valid, 1'b0);
        check("idle_not_busy", busy, 1'b0);
        check("rsp_data_hold", exp_b ? rsp_b_data : rsp_a_data, d);
    endtask

    initial begin
        rst = 1'b1;
        req_a_valid = 1'b0; req_a_addr = '0;
        req_b_valid = 1'b0; req_b_addr = '0;
        flash_mem_waitrequest = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata = '0;
        tick(); tick();
        check("rst_read", flash_mem_read, 1'b0);
        check("rst_addr", flash_mem_address, 23'h0);
        check("rst_be", flash_mem_byteenable, 4'h0);
        check("rst_ready", {req_a_ready, req_b_ready}, 2'b00);
        check("rst_rsp_valid", {rsp_a_valid, rsp_b_valid}, 2'b00);
        check("rst_rsp_data", {rsp_a_data, rsp_b_data}, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);
        rst = 1'b0;
        tick();

        // Single A read at minimum latency.
        req_a_valid = 1'b1; req_a_addr = 23'h000010;
        txn(1'b0, 23'h000010, 0, 0, 32'hDEADBEEF);
        check("single_b_data", rsp_b_data, 32'h0);

        // Fresh reset, then simultaneous A/B: A first, then B.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_a_valid = 1'b1; req_a_addr = 23'h000100;
        req_b_valid = 1'b1; req_b_addr = 23'h000200;
        txn(1'b0, 23'h000100, 0, 1, 32'h11111111);
        txn(1'b1, 23'h000200, 0, 2, 32'h22222222);
        check("rr_a_kept", rsp_a_data, 32'h11111111);

        // Waitrequest for 5 cycles; data lands exactly on the terminal count.
        req_a_valid = 1'b1; req_a_addr = 23'h7ABCDE;
        txn(1'b0, 23'h7ABCDE, 5, TO, 32'hA5A55A5A);

        // Watchdog on a B read.
        req_b_valid = 1'b1; req_b_addr = 23'h000300;
        #1;
        check("tmo_ready_b", req_b_ready, 1'b1);
        tick();
        req_b_valid = 1'b0;
        #1;
        check("tmo_issue", flash_mem_read, 1'b1);
        tick();
        for (int k = 0; k <= TO; k++) begin
            check("tmo_early", rsp_b_valid | timeout_err, 1'b0);
            tick();
        end
        check("tmo_rsp_b", rsp_b_valid, 1'b1);
        check("tmo_err", timeout_err, 1'b1);
        check("tmo_data", rsp_b_data, 32'h0);
        check("tmo_rsp_a", rsp_a_valid, 1'b0);
        tick();
        check("tmo_err_pulse", timeout_err, 1'b0);
        req_a_valid = 1'b1; req_a_addr = 23'h000044;
        txn(1'b0, 23'h000044, 0, 0, 32'hC0FFEE00);

        // Spurious readdatavalid in IDLE.
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'h12345678;
        tick(); tick();
        check("spur_valid", rsp_a_valid | rsp_b_valid, 1'b0);
        check("spur_a_data", rsp_a_data, 32'hC0FFEE00);
        check("spur_b_data", rsp_b_data, 32'h0);
        flash_mem_readdatavalid = 1'b0;

        // A served last, so B wins this tie; reset it mid-ISSUE.
        req_a_valid = 1'b1; req_a_addr = 23'h000500;
        req_b_valid = 1'b1; req_b_addr = 23'h000600;
        #1;
        check("rr_tie_b", {req_a_ready, req_b_ready}, 2'b01);
        tick();
        flash_mem_waitrequest = 1'b1;
        #1;
        check("mid_issue", flash_mem_read, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_read", flash_mem_read, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", {req_a_ready, req_b_ready}, 2'b00);
        tick();
        rst = 1'b0;
        flash_mem_waitrequest = 1'b0;
        req_a_valid = 1'b0; req_b_valid = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata = 32'hCAFEF00D;
        tick();
        check("late_rdv_valid", rsp_a_valid | rsp_b_valid, 1'b0);
        check("late_rdv_data", {rsp_a_data, rsp_b_data}, 64'h0);
        flash_mem_readdatavalid = 1'b0;
        req_a_valid = 1'b1;
        req_b_valid = 1'b1;
        txn(1'b0, 23'h000500, 0, 0, 32'h55AA55AA);
        txn(1'b1, 23'h000600, 1, 3, 32'h66778899);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
